mb_ctrl: RTL and testbench



---
 rtl/mb_pkg.sv | 36 +++
 rtl/mb_pin_check.sv | 43 ++++
 rtl/mb_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mb_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mb_pkg.sv
// Shared encodings for the multibanco session controller: FSM states,
// keypad operation codes and screen message codes.
package mb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PIN_WAIT = 3'd1,
        MENU     = 3'd2,
        DISPENSE = 3'd3,
        BLOCKED  = 3'd4
    } state_e;

    localparam int ECRA_W = 5;
    localparam int OP_W   = 5;

    // Operation codes (one-hot on the keypad side)
    localparam logic [OP_W-1:0] C_SALDO = 5'b00001;
    localparam logic [OP_W-1:0] C_LEV   = 5'b00010;
    localparam logic [OP_W-1:0] C_DEP   = 5'b00100;
    localparam logic [OP_W-1:0] C_SAIR  = 5'b01000;

    // Screen message codes
    localparam logic [ECRA_W-1:0] E_IDLE       = 5'd0;
    localparam logic [ECRA_W-1:0] E_PIN        = 5'd1;
    localparam logic [ECRA_W-1:0] E_PIN_ERR    = 5'd2;
    localparam logic [ECRA_W-1:0] E_BLOQ       = 5'd3;
    localparam logic [ECRA_W-1:0] E_MENU       = 5'd4;
    localparam logic [ECRA_W-1:0] E_SALDO      = 5'd5;
    localparam logic [ECRA_W-1:0] E_LEV        = 5'd6;
    localparam logic [ECRA_W-1:0] E_SEM_FUNDOS = 5'd7;
    localparam logic [ECRA_W-1:0] E_DEP        = 5'd8;
    localparam logic [ECRA_W-1:0] E_OVF        = 5'd9;
    localparam logic [ECRA_W-1:0] E_COD_INV    = 5'd10;
    localparam logic [ECRA_W-1:0] E_ADEUS      = 5'd11;

endpackage

// File: rtl/mb_pin_check.sv
// PIN comparator with wrong-attempt counter and lockout flag.
// The counter survives card removal; only a correct PIN or reset clears it.
module mb_pin_check
    import mb_pkg::*;
#(
    parameter int               PIN_W     = 4,
    parameter logic [PIN_W-1:0] PIN_REF   = 4'b1111,
    parameter int               MAX_TRIES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             check,     // a PIN attempt is accepted this cycle
    input  logic [PIN_W-1:0] pin,
    output logic             pin_ok,    // combinational: pin matches reference
    output logic             lock_hit,  // combinational: this attempt locks the card
    output logic             bloq       // registered lockout flag
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic [TRY_W-1:0] tries;

    assign pin_ok   = (pin == PIN_REF);
    assign lock_hit = !pin_ok && ((tries + 1'b1) == TRY_W'(MAX_TRIES));

    // Count wrong attempts and raise the lockout flag on the last allowed one
    // NOTE: non-blocking (<=) for every flop so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tries <= '0;
            bloq  <= 1'b0;
        end else if (check) begin
            if (pin_ok) begin
                tries <= '0;
            end else begin
                tries <= tries + 1'b1;
                if (lock_hit)
                    bloq <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mb_ctrl.sv
// Clocked multibanco card-session controller: PIN entry with lockout,
// then balance / withdrawal / deposit / exit on a session balance register.
// Every output is a flop; responses appear one cycle after the input is sampled.
module mb_ctrl
    import mb_pkg::*;
#(
    parameter int                 PIN_W     = 4,
    parameter int                 COD_W     = 5,
    parameter int                 VAL_W     = 4,
    parameter int                 SALDO_W   = 4,
    parameter logic [PIN_W-1:0]   PIN_REF   = 4'b1111,
    parameter int                 MAX_TRIES = 3,
    parameter int                 DISP_CYC  = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic [PIN_W-1:0]   PIN,
    input  logic               PIN_VLD,
    input  logic [COD_W-1:0]   COD,
    input  logic               COD_VLD,
    input  logic [VAL_W-1:0]   VAL,
    input  logic [SALDO_W-1:0] SALDO,
    output logic [VAL_W-1:0]   VAL_OUT,
    output logic [SALDO_W-1:0] SALDO_OUT,
    output logic [4:0]         ECRA,
    output logic               PAR,
    output logic               BLOQ
);

    localparam int SUM_W = ((VAL_W > SALDO_W) ? VAL_W : SALDO_W) + 1;
    localparam int CNT_W = $clog2(DISP_CYC + 1);

    state_e             state;
    logic [SALDO_W-1:0] saldo_reg;
    logic [CNT_W-1:0]   disp_cnt;

    logic               pin_ok;
    logic               lock_hit;
    logic               pin_check;

    // Arithmetic is done one bit wider than either operand so a deposit carry
    // and a withdrawal larger than the balance are both visible.
    logic [SUM_W-1:0]   saldo_ext;
    logic [SUM_W-1:0]   val_ext;
    logic [SUM_W-1:0]   dep_sum;
    logic               dep_ovf;
    logic               lev_bad;
    logic               session;

    assign saldo_ext = SUM_W'(saldo_reg);
    assign val_ext   = SUM_W'(VAL);
    assign dep_sum   = saldo_ext + val_ext;
    assign dep_ovf   = (dep_sum >> SALDO_W) != '0;
    assign lev_bad   = (val_ext == '0) || (val_ext > saldo_ext);

    // A card pulled mid-session ends it regardless of any strobe that cycle.
    assign session   = (state == PIN_WAIT) || (state == MENU) || (state == DISPENSE);
    assign pin_check = (state == PIN_WAIT) && EN && PIN_VLD;

    assign SALDO_OUT = saldo_reg;

    mb_pin_check #(
        .PIN_W     (PIN_W),
        .PIN_REF   (PIN_REF),
        .MAX_TRIES (MAX_TRIES)
    ) u_pin_check (
        .clk      (CLK),
        .rst      (RST),
        .check    (pin_check),
        .pin      (PIN),
        .pin_ok   (pin_ok),
        .lock_hit (lock_hit),
        .bloq     (BLOQ)
    );

    // Session FSM with registered screen, dispense, balance and parity outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            saldo_reg <= '0;
            PAR       <= 1'b0;
            VAL_OUT   <= '0;
            ECRA      <= E_IDLE;
            disp_cnt  <= '0;
        end else if (session && !EN) begin
            state   <= IDLE;
            VAL_OUT <= '0;
            ECRA    <= E_ADEUS;
        end else begin
            case (state)
                IDLE: begin
                    if (EN) begin
                        saldo_reg <= SALDO;
                        PAR       <= ^SALDO;
                        ECRA      <= E_PIN;
                        state     <= PIN_WAIT;
                    end
                end

                PIN_WAIT: begin
                    if (PIN_VLD) begin
                        if (pin_ok) begin
                            ECRA  <= E_MENU;
                            state <= MENU;
                        end else if (lock_hit) begin
                            ECRA  <= E_BLOQ;
                            state <= BLOCKED;
                        end else begin
                            ECRA  <= E_PIN_ERR;
                        end
                    end
                end

                MENU: begin
                    if (COD_VLD) begin
                        case (COD)
                            COD_W'(C_SALDO): ECRA <= E_SALDO;
                            COD_W'(C_LEV): begin
                                if (lev_bad) begin
                                    ECRA <= E_SEM_FUNDOS;
                                end else begin
                                    saldo_reg <= SALDO_W'(saldo_ext - val_ext);
                                    PAR       <= ^(SALDO_W'(saldo_ext - val_ext));
                                    VAL_OUT   <= VAL;
                                    disp_cnt  <= CNT_W'(DISP_CYC);
                                    ECRA      <= E_LEV;
                                    state     <= DISPENSE;
                                end
                            end
                            COD_W'(C_DEP): begin
                                if (dep_ovf) begin
                                    ECRA <= E_OVF;
                                end else begin
                                    saldo_reg <= SALDO_W'(dep_sum);
                                    PAR       <= ^(SALDO_W'(dep_sum));
                                    ECRA      <= E_DEP;
                                end
                            end
                            COD_W'(C_SAIR): begin
                                ECRA  <= E_ADEUS;
                                state <= IDLE;
                            end
                            default: ECRA <= E_COD_INV;
                        endcase
                    end
                end

                DISPENSE: begin
                    // VAL_OUT was loaded on entry; the last count drops it
                    if (disp_cnt == CNT_W'(1)) begin
                        VAL_OUT <= '0;
                        ECRA    <= E_MENU;
                        state   <= MENU;
                    end else begin
                        disp_cnt <= disp_cnt - 1'b1;
                    end
                end

                BLOCKED: ;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mb_ctrl.sv
// Directed bench for mb_ctrl. Each stimulus cycle pushes the hand-computed
// output snapshot expected after the next rising edge; a monitor on the
// falling edge pops and compares it against the DUT.
module tb_mb_ctrl;
    import mb_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic [3:0] PIN = '0;
    logic       PIN_VLD = 1'b0;
    logic [4:0] COD = '0;
    logic       COD_VLD = 1'b0;
    logic [3:0] VAL = '0;
    logic [3:0] SALDO = '0;
    logic [3:0] VAL_OUT;
    logic [3:0] SALDO_OUT;
    logic [4:0] ECRA;
    logic       PAR;
    logic       BLOQ;

    typedef struct {
        int    vo;
        int    so;
        int    ec;
        int    par;
        int    bq;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mb_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .PIN       (PIN),
        .PIN_VLD   (PIN_VLD),
        .COD       (COD),
        .COD_VLD   (COD_VLD),
        .VAL       (VAL),
        .SALDO     (SALDO),
        .VAL_OUT   (VAL_OUT),
        .SALDO_OUT (SALDO_OUT),
        .ECRA      (ECRA),
        .PAR       (PAR),
        .BLOQ      (BLOQ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare the DUT against the oldest pending expectation
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, " VAL_OUT"},   int'(VAL_OUT),   e.vo);
            check({e.tag, " SALDO_OUT"}, int'(SALDO_OUT), e.so);
            check({e.tag, " ECRA"},      int'(ECRA),      e.ec);
            check({e.tag, " PAR"},       int'(PAR),       e.par);
            check({e.tag, " BLOQ"},      int'(BLOQ),      e.bq);
        end
    end

    // One clock of stimulus: inputs are already driven; strobes last one cycle
    task automatic step(input int vo, input int so, input int ec,
                        input int par, input int bq, input string tag);
        exp_t e;
        @(posedge CLK);
        #1;
        PIN_VLD = 1'b0;
        COD_VLD = 1'b0;
        e.vo = vo; e.so = so; e.ec = ec; e.par = par; e.bq = bq; e.tag = tag;
        exp_q.push_back(e);
        @(negedge CLK);
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        RST = 1'b1;
        EN = 1'b0;
        PIN_VLD = 1'b0;
        COD_VLD = 1'b0;
        @(posedge CLK);
        #1;
        e.vo = 0; e.so = 0; e.ec = int'(E_IDLE); e.par = 0; e.bq = 0; e.tag = tag;
        exp_q.push_back(e);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic pin_in(input logic [3:0] p);
        PIN = p;
        PIN_VLD = 1'b1;
    endtask

    task automatic op_in(input logic [4:0] c, input logic [3:0] v);
        COD = c;
        VAL = v;
        COD_VLD = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and good-PIN session with a timed withdrawal
        @(negedge CLK);
        do_reset("reset");
        SALDO = 4'd9; EN = 1'b1;
        step(0, 9, E_PIN, 0, 0, "t1 start");
        pin_in(4'b1111);
        step(0, 9, E_MENU, 0, 0, "t1 pin ok");
        op_in(C_LEV, 4'd4);
        step(4, 5, E_LEV, 0, 0, "t3 lev c1");
        op_in(C_DEP, 4'd1);                     // ignored while dispensing
        step(4, 5, E_LEV, 0, 0, "t3 lev c2");
        step(4, 5, E_LEV, 0, 0, "t3 lev c3");
        step(4, 5, E_LEV, 0, 0, "t3 lev c4");
        step(0, 5, E_MENU, 0, 0, "t3 lev end");
        op_in(C_SAIR, 4'd0);
        step(0, 5, E_ADEUS, 0, 0, "t3 exit");
        EN = 1'b0;
        step(0, 5, E_ADEUS, 0, 0, "t3 idle");

        // Insufficient funds, deposit overflow and the deposit boundary
        SALDO = 4'd3; EN = 1'b1;
        step(0, 3, E_PIN, 0, 0, "t4 start");
        pin_in(4'b1111);
        step(0, 3, E_MENU, 0, 0, "t4 pin ok");
        pin_in(4'b0001);                        // PIN strobe ignored in MENU
        step(0, 3, E_MENU, 0, 0, "t4 pin in menu");
        op_in(C_LEV, 4'd5);
        step(0, 3, E_SEM_FUNDOS, 0, 0, "t4 lev 5");
        op_in(C_DEP, 4'd13);
        step(0, 3, E_OVF, 0, 0, "t4 dep 13");
        op_in(C_DEP, 4'd12);
        step(0, 15, E_DEP, 0, 0, "t4 dep 12");
        op_in(C_LEV, 4'd0);
        step(0, 15, E_SEM_FUNDOS, 0, 0, "t4 lev 0");
        op_in(C_SALDO, 4'd0);
        step(0, 15, E_SALDO, 0, 0, "t4 saldo");

        // Invalid code, exit, and a fresh session
        op_in(5'b10000, 4'd0);
        step(0, 15, E_COD_INV, 0, 0, "t5 cod inv");
        op_in(C_SAIR, 4'd0);
        step(0, 15, E_ADEUS, 0, 0, "t5 exit");
        EN = 1'b0; SALDO = 4'd2;
        step(0, 15, E_ADEUS, 0, 0, "t5 idle");
        EN = 1'b1;
        step(0, 2, E_PIN, 1, 0, "t5 start");
        op_in(C_SAIR, 4'd0);                    // COD strobe ignored in PIN_WAIT
        step(0, 2, E_PIN, 1, 0, "t5 cod in pin");
        pin_in(4'b1111);
        step(0, 2, E_MENU, 1, 0, "t5 pin ok");

        // Card pulled mid-dispense; tries survive across sessions
        op_in(C_LEV, 4'd2);
        step(2, 0, E_LEV, 0, 0, "t6 lev c1");
        step(2, 0, E_LEV, 0, 0, "t6 lev c2");
        EN = 1'b0;
        step(0, 0, E_ADEUS, 0, 0, "t6 en drop");
        step(0, 0, E_ADEUS, 0, 0, "t6 idle");
        SALDO = 4'd7; EN = 1'b1;
        step(0, 7, E_PIN, 1, 0, "t6 s2 start");
        pin_in(4'b0001);
        step(0, 7, E_PIN_ERR, 1, 0, "t6 s2 wrong1");
        EN = 1'b0;
        step(0, 7, E_ADEUS, 1, 0, "t6 s2 exit");
        EN = 1'b1;
        step(0, 7, E_PIN, 1, 0, "t6 s3 start");
        pin_in(4'b0001);
        step(0, 7, E_PIN_ERR, 1, 0, "t6 s3 wrong2");
        pin_in(4'b0001);
        step(0, 7, E_BLOQ, 1, 1, "t6 s3 wrong3");

        // Blocked card ignores EN and a correct PIN
        EN = 1'b0;
        step(0, 7, E_BLOQ, 1, 1, "t2 bloq en0");
        EN = 1'b1; pin_in(4'b1111);
        step(0, 7, E_BLOQ, 1, 1, "t2 bloq pin");
        do_reset("t2 reset");

        // Three wrong PINs in one session
        SALDO = 4'd9; EN = 1'b1;
        step(0, 9, E_PIN, 0, 0, "t2 start");
        pin_in(4'b0001);
        step(0, 9, E_PIN_ERR, 0, 0, "t2 wrong1");
        pin_in(4'b0001);
        step(0, 9, E_PIN_ERR, 0, 0, "t2 wrong2");
        pin_in(4'b0001);
        step(0, 9, E_BLOQ, 0, 1, "t2 wrong3");
        do_reset("t2 reset2");

        // Asynchronous reset while cash is being dispensed
        SALDO = 4'd9; EN = 1'b1;
        step(0, 9, E_PIN, 0, 0, "ar start");
        pin_in(4'b1111);
        step(0, 9, E_MENU, 0, 0, "ar pin ok");
        op_in(C_LEV, 4'd4);
        step(4, 5, E_LEV, 0, 0, "ar lev c1");
        @(posedge CLK);
        #2;
        check("ar before rst VAL_OUT", int'(VAL_OUT), 4);
        RST = 1'b1;
        #1;
        check("ar async VAL_OUT", int'(VAL_OUT), 0);
        check("ar async ECRA", int'(ECRA), int'(E_IDLE));
        @(negedge CLK);
        do_reset("ar reset");

        @(negedge CLK);
        check("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
